regfile_op_sequencer: RTL
=========================

# regfile_op_sequencer

Command-driven initiator for the 32×32 register file: accepts one ALU-style command at a time, issues the two register reads, computes the result and writes it back through the register file write port. It sits between a command source (test controller or microcode unit) and the register file, owning all of the file's read/write enables. Results are also returned on a valid/ready response channel.

## Interface
- No parameters. Data width is fixed at 32 and index width at 5.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (IDLE only).
- cmd_op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 RD (read only).
- cmd_rs1, cmd_rs2, cmd_rd  in  5 each  source and destination indices.
- rf_read_enable_1, rf_read_enable_2  out  1  register file read enables.
- rf_read_index_1, rf_read_index_2  out  5  register file read indices.
- rf_read_data_1, rf_read_data_2  in  32  register file read data; registered, valid one cycle after the enable.
- rf_write_enable  out  1  register file write enable.
- rf_write_index  out  5  write index.
- rf_write_data  out  32  write data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  result.
- rsp_ovf  out  1  signed overflow flag (see Configuration).
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → READ → CALC → WRITE → RESP → IDLE.
- IDLE: cmd_ready=1. When cmd_valid is high, latch op, rs1, rs2 and rd, then go to READ.
- READ (exactly 1 cycle): both read enables are high, and the indices equal the latched rs1/rs2. For op RD, only rf_read_enable_1 is asserted.
- CALC (1 cycle): sample rf_read_data_1/2 and register the result:
  - ADD/SUB/AND/OR/XOR use 32-bit modulo arithmetic; carry-out is discarded.
  - SLL/SRL are logical shifts of A by B[4:0].
  - RD passes A.
- WRITE (1 cycle): rf_write_enable=1 with rf_write_index=rd and rf_write_data=result. The enable is suppressed when rd=0 or op=RD; the state is still traversed.
- RESP: rsp_valid=1 and rsp_data=result, held stable until rsp_ready is high. On that edge the FSM goes to IDLE.
- Outside their states, all enables are 0. Index and data outputs hold their last value.
- Reset values: state IDLE; cmd_ready=1; busy=0; rsp_valid=0; rsp_data=0; rsp_ovf=0; all rf_* outputs 0.
- Reset mid-operation: the in-flight command is dropped with no write and no response. Enables fall asynchronously with rst_n.

## Timing
- Command accepted at edge E0. Read enables are high during cycle E0–E1. Read data is valid in cycle E1–E2. Write enable is high in cycle E2–E3. rsp_valid first rises in the cycle after E3.
- Minimum command-to-command spacing is 5 cycles, with rsp_ready held high.
- cmd_ready is registered, so there is no combinational path from cmd_valid or rsp_ready to any output.
- Read-after-write hazard: a write lands at E3 and the next read enable is issued no earlier than E0+5. No forwarding is needed.
- rsp_valid with rsp_ready=0 stalls indefinitely. cmd_ready stays 0 throughout the stall.

## Configuration
- RF_SEQ_OVF_FLAG_EN defined: rsp_ovf is registered in CALC.
  - ADD: set when the operands have equal signs and the result sign differs.
  - SUB: set when the operands have different signs and the result sign differs from A.
  - All other ops: 0.
  - rsp_ovf is valid together with rsp_data.
- Not defined: rsp_ovf is tied to 0 and the overflow logic is absent.

## Test plan
- Preload r1=5 and r2=7. Send ADD rd=3, rs1=1, rs2=2 with rsp_ready=1 → read enables pulse 1 cycle after accept, write_enable pulses 3 cycles after accept with index 3 and data 12, and rsp_data=12.
- Send SUB rd=0 (r1=5, r2=7) → rf_write_enable never asserts, rsp_data=0xFFFFFFFE, and a following RD rs1=0 returns 0.
- Hold rsp_ready=0 for 10 cycles after an XOR → rsp_valid and rsp_data stay stable, and cmd_ready=0 throughout; releasing rsp_ready returns the FSM to IDLE next edge.
- Run SLL with r1=1, r2=0x25 → result 0x20 (shift by 5). Then immediately RD of rd → returns 0x20, confirming write-then-read ordering.
- Assert rst_n=0 during the CALC cycle → all enables and rsp_valid go to 0 immediately, no write occurs, and after release cmd_ready=1.
- With RF_SEQ_OVF_FLAG_EN, ADD 0x7FFFFFFF+1 → rsp_data=0x80000000 and rsp_ovf=1. Without the macro, the same ADD gives rsp_ovf=0.

Source files
------------

// File: rtl/regfile_op_sequencer.sv
// Command sequencer for a 32x32 register file: read two operands, compute, write back, respond.
// Optional feature: define RF_SEQ_OVF_FLAG_EN to register a signed overflow flag on rsp_ovf.
module regfile_op_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [4:0]  cmd_rd,
    output logic        rf_read_enable_1,
    output logic        rf_read_enable_2,
    output logic [4:0]  rf_read_index_1,
    output logic [4:0]  rf_read_index_2,
    input  logic [31:0] rf_read_data_1,
    input  logic [31:0] rf_read_data_2,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_index,
    output logic [31:0] rf_write_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_ovf,
    output logic        busy
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpSll = 3'b101;
    localparam logic [2:0] OpSrl = 3'b110;
    localparam logic [2:0] OpRd  = 3'b111;

    typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic [4:0]  rs1_q, rs2_q, rd_q, wr_idx_q;
    logic [31:0] result_q, result_d;
    logic [31:0] a, b;

    assign a = rf_read_data_1;
    assign b = rf_read_data_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StRead;
            StRead:  state_d = StCalc;
            StCalc:  state_d = StWrite;
            StWrite: state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command fields double as the read indices, so they reset to 0 and hold between commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OpAdd;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
        end else if (state_q == StIdle && cmd_valid) begin
            op_q  <= cmd_op;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            rd_q  <= cmd_rd;
        end
    end

    always_comb begin
        result_d = '0;
        unique case (op_q)
            OpAdd:   result_d = a + b;
            OpSub:   result_d = a - b;
            OpAnd:   result_d = a & b;
            OpOr:    result_d = a | b;
            OpXor:   result_d = a ^ b;
            OpSll:   result_d = a << b[4:0];
            OpSrl:   result_d = a >> b[4:0];
            OpRd:    result_d = a;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            wr_idx_q <= '0;
        end else if (state_q == StCalc) begin
            result_q <= result_d;
            wr_idx_q <= rd_q;
        end
    end

`ifdef RF_SEQ_OVF_FLAG_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = 1'b0;
        case (op_q)
            OpAdd:   ovf_d = (a[31] == b[31]) && (result_d[31] != a[31]);
            OpSub:   ovf_d = (a[31] != b[31]) && (result_d[31] != a[31]);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == StCalc) begin
            ovf_q <= ovf_d;
        end
    end

    assign rsp_ovf = ovf_q;
`else
    assign rsp_ovf = 1'b0;
`endif

    // Outputs decode only flops, so enables drop as soon as reset clears the state.
    assign cmd_ready        = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign rf_read_enable_1 = (state_q == StRead);
    assign rf_read_enable_2 = (state_q == StRead) && (op_q != OpRd);
    assign rf_read_index_1  = rs1_q;
    assign rf_read_index_2  = rs2_q;
    assign rf_write_enable  = (state_q == StWrite) && (wr_idx_q != 5'd0) && (op_q != OpRd);
    assign rf_write_index   = wr_idx_q;
    assign rf_write_data    = result_q;
    assign rsp_valid        = (state_q == StResp);
    assign rsp_data         = result_q;

endmodule
